// File: rtl/cd_subq_pkg.sv
// Shared definitions for the CD Q-subcode deframer.
// Optional CRC checking is selected with the QSUB_CRC_EN macro.
package cd_subq_pkg;

  localparam int          QBITS     = 96;
  localparam int          QCRC_BITS = 80;
  localparam logic [15:0] QCRC_POLY = 16'h1021;

  typedef logic [11:0][7:0] q_frame_t;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } qsub_state_t;

  // Saturating 8-bit increment for the discard counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/qsub_crc16_serial.sv
// Serial MSB-first CRC-16 (poly 0x1021, init 0x0000).
// Only instantiated when QSUB_CRC_EN is defined.
module qsub_crc16_serial
  import cd_subq_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb_s;

  // Next CRC value: clear wins over shift, otherwise hold
  always_comb begin
    crc_d = crc_q;
    fb_s  = crc_q[15] ^ din;
    if (clr) begin
      crc_d = 16'h0000;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb_s ? QCRC_POLY : 16'h0000);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register (clr also covers system reset)
  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/q_subcode_deframer.sv
// Q subcode deframer: synchronises the DSP subcode pins, assembles the
// 96-bit Q channel between sector syncs and publishes 12-byte frames.
// Build option: QSUB_CRC_EN enables the CRC-16 check; without it every
// complete frame is published and crc_ok is tied high.
module q_subcode_deframer
  import cd_subq_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [19:0] BIT_TIMEOUT = 20'd650000
) (
  input  logic            CLK50MHZ,
  input  logic            rst,
  input  logic            sub_sync,
  input  logic            sub_clk,
  input  logic            sub_q,
  output logic [11:0][7:0] q_frame,
  output logic            q_valid,
  output logic            crc_ok,
  output logic [7:0]      err_cnt
);

  logic [SYNC_STAGES-1:0] ssync_q, ssync_d;
  logic [SYNC_STAGES-1:0] sclk_q,  sclk_d;
  logic [SYNC_STAGES-1:0] sdat_q,  sdat_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   clk_prev_q,  clk_prev_d;

  logic sync_edge_s;
  logic clk_edge_s;
  logic din_s;

  qsub_state_t      state_q, state_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [QBITS-1:0] shreg_q, shreg_d;
  logic [19:0]      tmo_q, tmo_d;
  logic [7:0]       err_q, err_d;
  q_frame_t         frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             crc_pass_s;

`ifdef QSUB_CRC_EN
  logic        crc_ok_q, crc_ok_d;
  logic        start_s;
  logic        crc_clr_s;
  logic        crc_en_s;
  logic [15:0] crc_val_s;

  // A sync edge restarts a frame in every state except the one-cycle CHECK
  assign start_s   = sync_edge_s && (state_q != CHECK);
  assign crc_clr_s = rst || start_s;
  assign crc_en_s  = (state_q == SHIFT) && clk_edge_s && !sync_edge_s &&
                     (bit_cnt_q < 7'(QCRC_BITS));

  qsub_crc16_serial u_crc (
    .clk (CLK50MHZ),
    .clr (crc_clr_s),
    .en  (crc_en_s),
    .din (din_s),
    .crc (crc_val_s)
  );

  // Transmitted CRC is the inverted remainder of the first 80 bits
  assign crc_pass_s = (~crc_val_s == shreg_q[15:0]);
`else
  assign crc_pass_s = 1'b1;
`endif

  // Synchroniser shift chains and edge-detect history
  always_comb begin
    ssync_d     = {ssync_q[SYNC_STAGES-2:0], sub_sync};
    sclk_d      = {sclk_q[SYNC_STAGES-2:0],  sub_clk};
    sdat_d      = {sdat_q[SYNC_STAGES-2:0],  sub_q};
    sync_prev_d = ssync_q[SYNC_STAGES-1];
    clk_prev_d  = sclk_q[SYNC_STAGES-1];
  end

  assign sync_edge_s = ssync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign clk_edge_s  = sclk_q[SYNC_STAGES-1]  & ~clk_prev_q;
  assign din_s       = sdat_q[SYNC_STAGES-1];

  // Frame FSM: next state, shift register, timeout and output staging
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = 20'd0;
    err_d     = err_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
`ifdef QSUB_CRC_EN
    crc_ok_d  = crc_ok_q;
`endif
    case (state_q)
      HUNT: begin
        if (sync_edge_s) begin
          bit_cnt_d = 7'd0;
          shreg_d   = '0;
          state_d   = SHIFT;
        end else begin
          state_d   = HUNT;
        end
      end
      SHIFT: begin
        if (sync_edge_s) begin
          // Sync before 96 bits: short frame, restart collection
          err_d     = sat_inc8(err_q);
          bit_cnt_d = 7'd0;
          shreg_d   = '0;
          state_d   = SHIFT;
        end else if (clk_edge_s) begin
          shreg_d   = {shreg_q[QBITS-2:0], din_s};
          bit_cnt_d = bit_cnt_q + 7'd1;
          if (bit_cnt_q == 7'(QBITS - 1)) begin
            state_d = CHECK;
          end else begin
            state_d = SHIFT;
          end
        end else if (tmo_q >= (BIT_TIMEOUT - 20'd1)) begin
          err_d   = sat_inc8(err_q);
          state_d = HUNT;
        end else begin
          tmo_d   = tmo_q + 20'd1;
        end
      end
      CHECK: begin
        if (crc_pass_s) begin
          frame_d  = q_frame_t'(shreg_q);
          valid_d  = 1'b1;
`ifdef QSUB_CRC_EN
          crc_ok_d = 1'b1;
`endif
        end else begin
          err_d    = sat_inc8(err_q);
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (sync_edge_s) begin
          bit_cnt_d = 7'd0;
          shreg_d   = '0;
          state_d   = SHIFT;
        end else if (clk_edge_s) begin
          // Extra strobe after a full frame: long frame
          err_d   = sat_inc8(err_q);
          state_d = HUNT;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      ssync_q     <= '0;
      sclk_q      <= '0;
      sdat_q      <= '0;
      sync_prev_q <= 1'b0;
      clk_prev_q  <= 1'b0;
      state_q     <= HUNT;
      bit_cnt_q   <= 7'd0;
      shreg_q     <= '0;
      tmo_q       <= 20'd0;
      err_q       <= 8'd0;
      frame_q     <= '0;
      valid_q     <= 1'b0;
`ifdef QSUB_CRC_EN
      crc_ok_q    <= 1'b0;
`endif
    end else begin
      ssync_q     <= ssync_d;
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      sync_prev_q <= sync_prev_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      valid_q     <= valid_d;
`ifdef QSUB_CRC_EN
      crc_ok_q    <= crc_ok_d;
`endif
    end
  end

  assign q_frame = frame_q;
  assign q_valid = valid_q;
  assign err_cnt = err_q;
`ifdef QSUB_CRC_EN
  assign crc_ok  = crc_ok_q;
`else
  assign crc_ok  = 1'b1;
`endif

endmodule

// File: tb/tb_q_subcode_deframer.sv
// Self-checking bench for q_subcode_deframer: directed scenarios plus
// random frames, compared against a byte-level frame/CRC model.
module tb_q_subcode_deframer;

  localparam logic [19:0] TMO = 20'd300;

  logic             CLK50MHZ = 1'b0;
  logic             rst      = 1'b1;
  logic             sub_sync = 1'b0;
  logic             sub_clk  = 1'b0;
  logic             sub_q    = 1'b0;
  logic [11:0][7:0] q_frame;
  logic             q_valid;
  logic             crc_ok;
  logic [7:0]       err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  logic [95:0] exp_frame     = '0;
  logic        exp_crc_ok    = 1'b0;
  int          exp_err       = 0;
  int          exp_valid_cnt = 0;

  // Monitor state
  int          valid_cnt   = 0;
  int          stable_viol = 0;
  logic [95:0] cap_frame   = '0;
  logic [95:0] prev_frame  = '0;
  logic        prev_rst    = 1'b1;

  q_subcode_deframer #(
    .SYNC_STAGES (2),
    .BIT_TIMEOUT (TMO)
  ) dut (
    .CLK50MHZ (CLK50MHZ),
    .rst      (rst),
    .sub_sync (sub_sync),
    .sub_clk  (sub_clk),
    .sub_q    (sub_q),
    .q_frame  (q_frame),
    .q_valid  (q_valid),
    .crc_ok   (crc_ok),
    .err_cnt  (err_cnt)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  // Count valid cycles and watch q_frame for changes without q_valid
  always @(negedge CLK50MHZ) begin
    if (q_valid) begin
      valid_cnt = valid_cnt + 1;
      cap_frame = q_frame;
    end
    if (!q_valid && !prev_rst && (q_frame !== prev_frame)) begin
      stable_viol = stable_viol + 1;
    end
    prev_frame = q_frame;
    prev_rst   = rst;
  end

  function automatic logic [15:0] model_crc(input logic [79:0] msg);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      b = msg[79 - 8*k -: 8];
      c = c ^ {b, 8'h00};
      for (int j = 0; j < 8; j++) begin
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic logic [95:0] make_frame(input logic [79:0] msg);
    return {msg, ~model_crc(msg)};
  endfunction

  function automatic logic model_ok(input logic [95:0] f);
`ifdef QSUB_CRC_EN
    return (~model_crc(f[95:16]) == f[15:0]);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_err8();
    return (exp_err > 255) ? 8'hFF : 8'(exp_err);
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK50MHZ);
  endtask

  task automatic send_bit(input logic b);
    sub_q = b;
    wait_cycles(3);
    sub_clk = 1'b1;
    wait_cycles(3);
    sub_clk = 1'b0;
    wait_cycles(2);
  endtask

  task automatic send_sync();
    sub_sync = 1'b1;
    wait_cycles(3);
    sub_sync = 1'b0;
    wait_cycles(3);
  endtask

  task automatic send_bits(input logic [95:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(f[95 - i]);
    end
  endtask

  // Model outcome of a complete 96-bit frame
  task automatic model_frame(input logic [95:0] f);
    if (model_ok(f)) begin
      exp_frame  = f;
      exp_crc_ok = 1'b1;
      exp_valid_cnt++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid_cnt"}, 96'(valid_cnt), 96'(exp_valid_cnt));
    check({tag, ".q_frame"},   q_frame,        exp_frame);
    check({tag, ".crc_ok"},    96'(crc_ok),    96'(exp_crc_ok));
    check({tag, ".err_cnt"},   96'(err_cnt),   96'(exp_err8()));
  endtask

  task automatic run_frame(input string tag, input logic [95:0] f);
    send_sync();
    send_bits(f, 96);
    wait_cycles(10);
    model_frame(f);
    check_all(tag);
  endtask

  initial begin
    logic [95:0] f;
    logic [79:0] msg;
    logic [7:0]  b11;
    logic [7:0]  b2;
    int          pos;

`ifdef QSUB_CRC_EN
    exp_crc_ok = 1'b0;
`else
    exp_crc_ok = 1'b1;
`endif

    // Reset state
    rst = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(2);
    check("reset.q_valid", 96'(q_valid), 96'(0));
    check_all("reset");

    // Known valid frame
    msg = 80'h41_01_01_00_02_00_00_00_04_00;
    f   = make_frame(msg);
    run_frame("valid", f);
    b11 = q_frame[11];
    b2  = q_frame[2];
    check("valid.byte11", 96'(b11), 96'(8'h41));
    check("valid.byte2",  96'(b2),  96'(8'h00));
    check("valid.capture", cap_frame, f);

    // Same frame with bit 50 flipped
    f[95 - 50] = ~f[95 - 50];
    run_frame("flip50", f);

    // Short frame (60 bits) followed by a valid frame
    f = make_frame({$urandom, $urandom, 16'($urandom)});
    send_sync();
    send_bits(f, 60);
    exp_err++;
    run_frame("short_then_valid", f);

    // Long frame: accepted at bit 96, error at bit 97, then HUNT
    f = make_frame({$urandom, $urandom, 16'($urandom)});
    send_sync();
    send_bits(f, 96);
    wait_cycles(10);
    model_frame(f);
    check_all("long.bit96");
    send_bit(1'b1);
    wait_cycles(10);
    exp_err++;
    check_all("long.bit97");
    send_bits(make_frame(80'h0123456789abcdef0123), 96);
    wait_cycles(10);
    check_all("long.hunt_ignores");

    // Timeout after 40 bits, then strobes ignored until sync
    f = make_frame({$urandom, $urandom, 16'($urandom)});
    send_sync();
    send_bits(f, 40);
    wait_cycles(int'(TMO) + 50);
    exp_err++;
    check_all("timeout");
    send_bits(f, 96);
    wait_cycles(10);
    check_all("timeout.hunt_ignores");

    // Reset in the middle of a frame
    send_sync();
    send_bits(f, 30);
    rst = 1'b1;
    wait_cycles(1);
    exp_frame = '0;
    exp_err   = 0;
`ifdef QSUB_CRC_EN
    exp_crc_ok = 1'b0;
`endif
    check("midrst.q_valid", 96'(q_valid), 96'(0));
    check_all("midrst");
    rst = 1'b0;
    wait_cycles(2);
    run_frame("midrst.next", make_frame({$urandom, $urandom, 16'($urandom)}));

    // Random frames, roughly half with one corrupted bit
    for (int n = 0; n < 8; n++) begin
      f = make_frame({$urandom, $urandom, 16'($urandom)});
      if ($urandom_range(1, 0) == 1) begin
        pos = $urandom_range(95, 0);
        f[pos] = ~f[pos];
      end
      run_frame("random", f);
    end

    check("stable_between_valid", 96'(stable_viol), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/q_subcode_deframer.md
# q_subcode_deframer

Recovers the 96-bit Q subcode channel from the CD DSP serial subcode pins, aligns it to the sector sync, and checks the CRC-16. It presents each complete sector's Q data as a 12-byte frame, with a one-cycle valid strobe and a CRC flag. The block sits directly upstream of the UART hex-dump transmitter and drives that stage's 12-byte message input.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flops on each asynchronous DSP input (≥2)
- BIT_TIMEOUT, 20'd650000, CLK50MHZ cycles without a subcode strobe before the frame aborts (13 ms)

Ports:
- CLK50MHZ  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sub_sync  in  1  asynchronous sector sync from DSP (SCOR), active-high pulse ≥2 clocks
- sub_clk  in  1  asynchronous subcode symbol strobe; Q bit is valid on its rising edge
- sub_q  in  1  asynchronous Q subcode data bit
- q_frame  out  [11:0][7:0]  last accepted frame; [11] = first received byte (CTRL/ADR), [0] = CRC low byte
- q_valid  out  1  one-cycle pulse when q_frame updates
- crc_ok  out  1  CRC result of the frame currently on q_frame
- err_cnt  out  8  saturating count of discarded frames (CRC, short, long, timeout)

## Operation
- All three DSP inputs pass through SYNC_STAGES flops. Rising edges of synced sub_clk and sub_sync come from a further edge-detect flop.
- FSM states: HUNT, SHIFT, CHECK, HOLD.
  - HUNT: ignore strobes. A sub_sync rising edge clears bit_cnt (7 bit), the shift register and the CRC, then goes to SHIFT.
  - SHIFT: each sub_clk edge shifts sub_q into a 96-bit register, MSB first, and increments bit_cnt. Bits 0–79 also feed the serial CRC.
    - When bit_cnt reaches 96, go to CHECK.
    - A sub_sync edge with bit_cnt <96 counts a short frame: err_cnt++, restart SHIFT with cleared state.
    - Timeout between strobes: err_cnt++, go to HUNT.
  - CHECK (1 cycle): the received CRC is the last 16 bits.
    - Pass if bitwise-inverted computed CRC equals the received CRC.
    - On pass: load q_frame, set crc_ok=1, pulse q_valid.
    - On fail: err_cnt++; q_frame and crc_ok are unchanged.
    - Then go to HOLD.
  - HOLD: wait for sub_sync.
    - A sub_sync edge starts the next frame exactly as from HUNT.
    - A sub_clk edge in HOLD means the frame is long: err_cnt++, go to HUNT.
- CRC: polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000, serial, MSB first.
- err_cnt saturates at 8'hFF.
- Simultaneous sub_sync and sub_clk edges: sync wins and the strobe is dropped.

## Timing
- Reset values: q_frame=0, q_valid=0, crc_ok=0, err_cnt=0, state=HUNT, timeout counter=0.
- Pin-to-edge latency is SYNC_STAGES+1 cycles.
- The 96th strobe edge is followed by CHECK on the next cycle. q_valid asserts the cycle after CHECK, so q_frame and q_valid change together.
- q_frame is stable between q_valid pulses. The downstream stage samples it at any time without a handshake. The sector period of 13.3 ms exceeds the 37-character UART dump time of about 3.2 ms.
- The timeout counter clears on every sub_clk edge and on sync. It is only active in SHIFT.
- rst mid-frame takes effect on the next edge. The partial frame is lost and is not counted as an error.

## Configuration
- QSUB_CRC_EN defined: CRC checked as above; failing frames are discarded and counted.
- QSUB_CRC_EN undefined: no CRC logic is built; every 96-bit frame is loaded; crc_ok is tied 1. err_cnt counts only short, long and timeout frames.

## Structure
- Package cd_subq_pkg holds:
  - QBITS=96 and QCRC_POLY=16'h1021
  - typedef q_frame_t (logic [11:0][7:0])
  - state enum qsub_state_t
- One sub-module, qsub_crc16_serial, with ports clk, clr, en, din and crc[15:0]. It is instantiated only under QSUB_CRC_EN.

## Test plan
- Valid frame: sync, then 96 bits with bytes 41 01 01 00 02 00 00 00 04 00 plus the bench-model CRC. Required: q_valid 1 cycle, q_frame[11]=8'h41, q_frame[2]=8'h00, crc_ok=1, err_cnt=0.
- Same frame with bit 50 flipped. Required: no q_valid, q_frame unchanged, err_cnt=1. With the macro undefined: q_valid with crc_ok=1.
- Sync after 60 bits, then a full valid frame. Required: err_cnt=1, and the second frame is accepted.
- 97 strobes after sync. Required: frame accepted at bit 96, err_cnt=1 at bit 97, state HUNT.
- Strobes stop after 40 bits for >BIT_TIMEOUT cycles. Required: err_cnt=1, state HUNT, and strobes are ignored until the next sync.
- rst asserted at bit 30. Required: all outputs return to reset values next cycle, and the following valid frame is accepted.
